// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive stimulus engine for an N_IN-input, 1-output
// combinational block. Steps vec_out through 0..2^N_IN-1, holds each vector
// HOLD clocks, samples dut_out on the last hold clock and scores it against a
// golden truth table captured when the sweep was started.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int HOLD = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [2**N_IN-1:0]   i_expected,
  input  logic                 i_dut_out,
  output logic [N_IN-1:0]      o_vec_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [N_IN:0]        o_err_count,
  output logic [N_IN-1:0]      o_first_err_idx,
  output logic [2**N_IN-1:0]   o_captured
);

  // hold counter needs at least one bit even when HOLD==1
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [HW-1:0]       r_hold;
  logic [2**N_IN-1:0]  r_tbl;
  logic [N_IN-1:0]     r_vec;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [N_IN:0]       r_err;
  logic [N_IN-1:0]     r_first;
  logic [2**N_IN-1:0]  r_cap;

  logic                w_mis;
  logic [N_IN:0]       w_err_nxt;

  // mismatch of the current vector and the error count including it, so pass
  // can be decided on the same edge that ends the sweep
  assign w_mis     = i_dut_out ^ r_tbl[r_vec];
  assign w_err_nxt = r_err + {{N_IN{1'b0}}, w_mis};

  // sweep sequencer: start acceptance, hold timing, sampling and scoring
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_tbl   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
      r_cap   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_tbl   <= i_expected;
            r_err   <= '0;
            r_first <= '0;
            r_cap   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_vec   <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_hold != HOLD_LAST) begin
            r_hold <= r_hold + HW'(1);
          end else begin
            r_cap[r_vec] <= i_dut_out;
            r_err        <= w_err_nxt;
            if (w_mis && (r_err == '0)) r_first <= r_vec;
            if (r_vec == VEC_LAST) begin
              // sweep ends at all-ones; vec_out keeps the last vector
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == '0);
            end else begin
              r_vec  <= r_vec + N_IN'(1);
              r_hold <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_vec_out       = r_vec;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_err_count     = r_err;
  assign o_first_err_idx = r_first;
  assign o_captured      = r_cap;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: drives two sweeper instances (3-input/HOLD=4 and
// 4-input/HOLD=1) against behavioural DUT models and scores them through a
// queue of per-cycle and end-of-sweep expectations.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: N_IN=3, HOLD=4
  logic        stA;
  logic [7:0]  expA;
  logic        dA;
  logic [2:0]  vA, fA;
  logic        bA, dnA, pA;
  logic [3:0]  eA;
  logic [7:0]  cA;
  int          modeA;

  // instance B: N_IN=4, HOLD=1
  logic        stB;
  logic [15:0] expB;
  logic        dB;
  logic [3:0]  vB, fB;
  logic        bB, dnB, pB;
  logic [4:0]  eB;
  logic [15:0] cB;

  truth_table_sweeper #(.N_IN(3), .HOLD(4)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(stA), .i_expected(expA), .i_dut_out(dA),
    .o_vec_out(vA), .o_busy(bA), .o_done(dnA), .o_pass(pA),
    .o_err_count(eA), .o_first_err_idx(fA), .o_captured(cA));

  truth_table_sweeper #(.N_IN(4), .HOLD(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(stB), .i_expected(expB), .i_dut_out(dB),
    .o_vec_out(vB), .o_busy(bB), .o_done(dnB), .o_pass(pB),
    .o_err_count(eB), .o_first_err_idx(fB), .o_captured(cB));

  // DUT models: 0 majority, 1 stuck-at-0, 2 majority with vector 6 inverted
  function automatic logic model3(input int m, input logic [2:0] v);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      1:       return 1'b0;
      2:       return maj ^ (v == 3'd6);
      default: return maj;
    endcase
  endfunction

  always_comb dA = model3(modeA, vA);
  assign dB = ^vB;

  typedef struct packed {
    logic [3:0]  vec;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  first;
    logic [15:0] cap;
  } obs_t;

  obs_t oA, oB;
  always_comb oA = {1'b0, vA, bA, dnA, pA, 1'b0, eA, 1'b0, fA, 8'h00, cA};
  always_comb oB = {vB, bB, dnB, pB, eB, fB, cB};

  typedef struct { int vec; bit busy; bit done; bit pass; } cyc_t;
  typedef struct { int err; int first; logic [15:0] cap; bit pass; } res_t;
  cyc_t cq[$];
  res_t rq[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic obs_t cur(input int s);
    return (s != 0) ? oB : oA;
  endfunction

  task automatic set_start(input int s, input logic v);
    if (s != 0) stB = v; else stA = v;
  endtask

  // one full sweep; mid_k >= 0 pulses start during RUN at that cycle offset
  task automatic sweep(input int s, input int mode, input logic [15:0] tbl, input int mid_k);
    int nv, hold, total, errs, first, ev;
    logic [15:0] cap;
    logic [3:0]  vv;
    logic        o;
    obs_t        ob;
    cyc_t        e;
    res_t        r;
    nv    = (s != 0) ? 16 : 8;
    hold  = (s != 0) ? 1 : 4;
    total = nv * hold;
    errs  = 0;
    first = 0;
    cap   = '0;
    for (int v = 0; v < nv; v++) begin
      vv = v[3:0];
      o  = (s != 0) ? ^vv : model3(mode, vv[2:0]);
      cap[v] = o;
      if (o != tbl[v]) begin
        if (errs == 0) first = v;
        errs++;
      end
    end
    for (int k = 0; k <= total; k++) begin
      ev = k / hold;
      if (ev > nv - 1) ev = nv - 1;
      cq.push_back('{ev, k < total, k == total, (k == total) && (errs == 0)});
    end
    rq.push_back('{errs, first, cap, errs == 0});

    if (s != 0) expB = tbl;
    else begin
      expA  = tbl[7:0];
      modeA = mode;
    end
    @(negedge clk);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    ob = cur(s);
    chk("clr", {4'b0, ob.err, ob.first, ob.cap}, 32'h0);
    for (int k = 0; k <= total; k++) begin
      if (k > 0) @(negedge clk);
      set_start(s, k == mid_k);
      ob = cur(s);
      e  = cq.pop_front();
      chk("vec", 32'(ob.vec), 32'(e.vec));
      chk("stat", 32'({ob.busy, ob.done, ob.pass}), 32'({e.busy, e.done, e.pass}));
    end
    set_start(s, 1'b0);
    ob = cur(s);
    r  = rq.pop_front();
    chk("err_count", 32'(ob.err), 32'(r.err));
    chk("first_err", 32'(ob.first), 32'(r.first));
    chk("captured", 32'(ob.cap), 32'(r.cap));
    chk("pass", 32'(ob.pass), 32'(r.pass));
    // results must stay frozen in DONE even if expected changes
    if (s != 0) expB = ~tbl; else expA = ~tbl[7:0];
    repeat (3) @(negedge clk);
    ob = cur(s);
    chk("done_hold", {ob.done, ob.busy, ob.pass, 8'h0, ob.err, ob.cap},
        {1'b1, 1'b0, r.pass, 8'h0, 5'(r.err), r.cap});
  endtask

  initial begin
    stA = 1'b0; stB = 1'b0;
    expA = '0;  expB = '0;
    modeA = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a", oA, 32'h0);
    chk("rst_b", oB, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    sweep(0, 0, 16'h00E8, -1);   // majority, all match
    sweep(0, 1, 16'h00E8, -1);   // stuck-at-0
    sweep(0, 2, 16'h00E8, -1);   // single bad vector 6
    sweep(0, 0, 16'h00E8, 9);    // start pulsed while vec_out==2
    sweep(0, 0, 16'h00E8, -1);   // restart from DONE

    // async reset while vec_out==5
    expA = 8'hE8; modeA = 0;
    @(negedge clk); stA = 1'b1;
    @(negedge clk); stA = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_vec", 32'(vA), 32'd5);
    #1 rst = 1'b1;
    #1 chk("arst", oA, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", oA, 32'h0);

    sweep(1, 0, 16'h6996, -1);   // 4-input XOR, HOLD=1

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // hard stop in case the sequence above is ever lengthened past its budget
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Parametrised, self-checking exhaustive-stimulus engine for N-input, 1-output combinational blocks. On start it drives every input combination 0..2^N_IN-1 in ascending order and holds each for HOLD clocks. It samples the DUT output on the last hold cycle and compares it against a golden truth table latched at start. It reports pass/fail, the error count, the first failing index and the full captured response. It is the clocked, synthesizable successor to hand-written sweep benches, and runs on FPGA or in simulation.

Parameters:
N_IN, 3, number of DUT inputs (1..8); sweep length 2^N_IN vectors
HOLD, 4, clocks each vector is held (>=1); the sample is taken on the last hold clock

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin a sweep; sampled in IDLE or DONE only
expected  input  2^N_IN  golden truth table; bit i = required output for input vector i; latched on accepted start
dut_out  input  1  DUT output under test
vec_out  output  N_IN  input vector driven to DUT (MSB = first DUT input)
busy  output  1  high while sweep in progress
done  output  1  high from sweep completion until next accepted start or reset
pass  output  1  done && err_count==0
err_count  output  N_IN+1  number of mismatching vectors (max 2^N_IN)
first_err_idx  output  N_IN  index of first mismatch; valid when err_count!=0, else 0
captured  output  2^N_IN  bit i = dut_out sampled for vector i

Behaviour:
- Reset (async assert, released synchronously by the clock domain) forces: state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, captured=0, hold counter=0, latched table=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge E:
  - latch expected;
  - clear err_count, first_err_idx, captured and done;
  - vec_out=0, hold_cnt=0, busy=1;
  - state goes to RUN from E.
- RUN, each edge:
  - if hold_cnt != HOLD-1: hold_cnt++.
  - else (sample edge):
    - captured[vec_out] <= dut_out;
    - if dut_out != latched[vec_out]: err_count++; if err_count==0, first_err_idx <= vec_out;
    - if vec_out == 2^N_IN-1: state=DONE, busy=0, done=1, vec_out holds its last value;
    - else vec_out++ and hold_cnt=0.
- Timing:
  - Vector i is driven for exactly HOLD clocks.
  - The sweep occupies 2^N_IN*HOLD clocks after E.
  - done rises at edge E + 2^N_IN*HOLD.
- Combinational DUT settles within the first HOLD-1 clocks; with HOLD=1 the DUT path must settle within one cycle.
- pass is registered alongside done: it goes high on the same edge as done when no error occurred, and clears on the next accepted start.
- start in RUN is ignored: no restart, no effect on counters.
- start held high is level-sensitive only in IDLE/DONE. If start is held high continuously, a new sweep begins on the edge after DONE is entered.
- vec_out wraps never: the sweep stops at all-ones.
- err_count saturates naturally at 2^N_IN because its width is N_IN+1.
- In DONE, all results stay stable until start or rst; changes on expected are ignored outside the start edge.
- rst asserted mid-RUN aborts immediately: all outputs return to their reset values, partial results are discarded, and the next sweep requires a fresh start.

Test Plan:
- N_IN=3, HOLD=4, expected=8'b1110_1000 (majority), DUT = majority(vec_out), pulse start -> vec_out steps 0..7 every 4 clks; done=1 and pass=1 at start+32 clks; err_count=0; captured=8'hE8.
- Same setup, dut_out tied 0 -> done at +32; pass=0; err_count=4; first_err_idx=3; captured=8'h00.
- DUT = majority XOR (vec==6) -> err_count=1, first_err_idx=6, captured=8'hA8, pass=0.
- start pulsed again at vec_out=2 mid-sweep -> ignored; sweep still completes at +32 with results unchanged. Then start from DONE -> results clear and a new sweep runs identically.
- rst asserted while vec_out=5 -> all outputs 0 immediately (asynchronously, not at next edge); after release, state stays IDLE until start.
- N_IN=4, HOLD=1, expected=16'h6996 (4-input XOR), DUT=XOR -> done at +16 clks; pass=1; err_count width 5 holds 0; captured=16'h6996.
